// File: rtl/wb_ctrl_if.sv
// Writeback controller bundle: issue port, single-beat memory read port,
// result-selector outputs and register-file write port.
interface wb_ctrl_if #(
    parameter int RW = 4
);
    logic          in_valid;
    logic          in_ready;
    logic [7:0]    in_opc;
    logic [1:0]    in_flg;
    logic [63:0]   in_c;
    logic [63:0]   in_addr;
    logic [RW-1:0] in_rd;

    logic          mem_req;
    logic [63:0]   mem_addr;
    logic          mem_ack;
    logic [63:0]   mem_rdata;

    logic [7:0]    sel_opc;
    logic [1:0]    sel_flg;
    logic [63:0]   sel_c;
    logic [63:0]   sel_d;

    logic          rf_we;
    logic [RW-1:0] rf_waddr;
    logic          err;

    // Controller side.
    modport master (
        input  in_valid, in_opc, in_flg, in_c, in_addr, in_rd,
        input  mem_ack, mem_rdata,
        output in_ready, mem_req, mem_addr,
        output sel_opc, sel_flg, sel_c, sel_d,
        output rf_we, rf_waddr, err
    );

    // Environment side: issue stage, memory and register file.
    modport slave (
        output in_valid, in_opc, in_flg, in_c, in_addr, in_rd,
        output mem_ack, mem_rdata,
        input  in_ready, mem_req, mem_addr,
        input  sel_opc, sel_flg, sel_c, sel_d,
        input  rf_we, rf_waddr, err
    );
endinterface

// File: rtl/wb_ctrl.sv
// Writeback controller: IDLE -> (RD) -> WB sequencer for the selector and register-file write port.
// Optional memory-ack timeout with sticky err is enabled by defining WBCTL_TIMEOUT_EN.
module wb_ctrl #(
    parameter int RW  = 4,
    parameter int TMO = 255
) (
    input  logic     clk,
    input  logic     rst_n,
    wb_ctrl_if.master bus
);
    // Memory-sourced move opcodes, encoding shared with inst.v.
    localparam logic [7:0] OPC_MOVRA4 = 8'h2c;
    localparam logic [7:0] OPC_MOVRA1 = 8'h2d;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WB   = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic          accept;
    logic          is_load;
    logic          ack_rd;
    logic          tmo_hit;

    logic [7:0]    opc_p0;
    logic [1:0]    flg_p0;
    logic [63:0]   c_p0;
    logic [63:0]   addr_p0;
    logic [63:0]   d_p0;
    logic [RW-1:0] rd_p0;

    assign accept  = bus.in_valid && (state == IDLE);
    assign is_load = !bus.in_opc[7] &&
                     ((bus.in_opc == OPC_MOVRA4) || (bus.in_opc == OPC_MOVRA1));
    assign ack_rd  = (state == RD) && bus.mem_ack;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = is_load ? RD : WB;
                end
            end
            RD: begin
                // An ack arriving on the timeout cycle still completes the load.
                if (bus.mem_ack) begin
                    state_nxt = WB;
                end else if (tmo_hit) begin
                    state_nxt = IDLE;
                end
            end
            WB:      state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

`ifdef WBCTL_TIMEOUT_EN
    localparam int CW = ($clog2(TMO + 1) > 8) ? $clog2(TMO + 1) : 8;

    logic [CW-1:0] tmo_cnt;
    logic          err_q;

    assign tmo_hit = (tmo_cnt == CW'(TMO - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt <= '0;
            err_q   <= 1'b0;
        end else begin
            if (accept) begin
                tmo_cnt <= '0;
            end else if ((state == RD) && !bus.mem_ack) begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end
            if ((state == RD) && !bus.mem_ack && tmo_hit) begin
                err_q <= 1'b1;
            end
        end
    end

    assign bus.err = err_q;
`else
    logic unused_tmo;

    assign unused_tmo = ^TMO;
    assign tmo_hit    = 1'b0;
    assign bus.err    = 1'b0;
`endif

    // Stage p0: holding registers captured on accept, sel_d overwritten by load data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opc_p0  <= '0;
            flg_p0  <= '0;
            c_p0    <= '0;
            addr_p0 <= '0;
            d_p0    <= '0;
            rd_p0   <= '0;
        end else if (accept) begin
            opc_p0  <= bus.in_opc;
            flg_p0  <= bus.in_flg;
            c_p0    <= bus.in_c;
            addr_p0 <= bus.in_addr;
            d_p0    <= bus.in_c;
            rd_p0   <= bus.in_rd;
        end else if (ack_rd) begin
            d_p0    <= bus.mem_rdata;
        end
    end

    assign bus.in_ready = (state == IDLE);
    assign bus.mem_req  = (state == RD);
    assign bus.rf_we    = (state == WB);
    assign bus.mem_addr = addr_p0;
    assign bus.sel_opc  = opc_p0;
    assign bus.sel_flg  = flg_p0;
    assign bus.sel_c    = c_p0;
    assign bus.sel_d    = d_p0;
    assign bus.rf_waddr = rd_p0;
endmodule

// File: tb/tb_wb_ctrl.sv
// Scoreboard bench for wb_ctrl: stimulus pushes expected writebacks, a monitor pops them on rf_we,
// and a memory model answers read requests with scripted latency and data.
module tb_wb_ctrl;
    localparam int RW     = 4;
    localparam int TMO_TB = 8;
    localparam logic [7:0] MOVRA4 = 8'h2c;
    localparam logic [7:0] MOVRA1 = 8'h2d;
    localparam logic [7:0] SETLE  = 8'h35;

    typedef struct {
        logic [7:0]    opc;
        logic [1:0]    flg;
        logic [63:0]   c;
        logic [63:0]   d;
        logic [RW-1:0] rd;
        int            obs;
    } wb_t;

    typedef struct {
        logic [63:0] addr;
        logic [63:0] rdata;
        int          dly;
    } mem_t;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   we_count = 0;
    wb_t  sb[$];
    mem_t mq[$];

    wb_ctrl_if #(.RW(RW)) bus ();

    wb_ctrl #(.RW(RW), .TMO(TMO_TB)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic bit model_is_load(input logic [7:0] opc);
        return (opc[7] == 1'b0) && ((opc == MOVRA4) || (opc == MOVRA1));
    endfunction

    // Offer one instruction; dly = ack latency in RD cycles, 0 = never ack, -1 = aborted by reset.
    task automatic issue(input logic [7:0] opc, input logic [1:0] flg, input logic [63:0] c,
                         input logic [63:0] addr, input logic [RW-1:0] rd, input int dly,
                         input logic [63:0] rdata, input bit hold);
        int  n;
        bit  ld;
        wb_t e;
        n = 0;
        forever begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            if (bus.in_ready) begin
                bus.in_opc = opc; bus.in_flg = flg; bus.in_c = c;
                bus.in_addr = addr; bus.in_rd = rd;
                ld = model_is_load(opc);
                if (ld) mq.push_back('{addr: addr, rdata: rdata, dly: dly});
                if (!ld || dly > 0) begin
                    e.opc = opc; e.flg = flg; e.c = c; e.rd = rd;
                    e.d   = ld ? rdata : c;
                    e.obs = cyc + 1 + (ld ? dly : 0);
                    sb.push_back(e);
                end
                @(posedge clk);
                #1 bus.in_valid = 1'b0;
                return;
            end
            if (!hold) begin
                bus.in_opc = 8'($urandom); bus.in_flg = 2'($urandom);
                bus.in_c = {$urandom, $urandom}; bus.in_addr = {$urandom, $urandom};
                bus.in_rd = RW'($urandom);
            end else begin
                bus.in_opc = opc; bus.in_flg = flg; bus.in_c = c;
                bus.in_addr = addr; bus.in_rd = rd;
            end
            n++;
            if (n > 1000) begin
                chk("ready_timeout", 1'b0, 1'b1);
                bus.in_valid = 1'b0;
                return;
            end
        end
    endtask

    // Monitor: every rf_we pulse must match the oldest expected writeback.
    initial begin
        wb_t e;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1) begin
                chk("ready_only_idle", bus.in_ready, !(bus.mem_req || bus.rf_we));
                if (bus.rf_we) begin
                    we_count++;
                    if (sb.size() == 0) begin
                        chk("unexpected_rf_we", 1'b1, 1'b0);
                    end else begin
                        e = sb.pop_front();
                        chk("rf_waddr", 64'(bus.rf_waddr), 64'(e.rd));
                        chk("sel_opc", 64'(bus.sel_opc), 64'(e.opc));
                        chk("sel_flg", 64'(bus.sel_flg), 64'(e.flg));
                        chk("sel_c", bus.sel_c, e.c);
                        chk("sel_d", bus.sel_d, e.d);
                        chk("we_cycle", 64'(cyc), 64'(e.obs));
                    end
                end
            end
        end
    end

    // Memory model: answers each request per its script, sprinkles stray acks outside requests.
    initial begin
        mem_t m;
        int   k;
        bus.mem_ack = 1'b0;
        bus.mem_rdata = '0;
        forever begin
            @(negedge clk);
            bus.mem_ack = 1'b0;
            if (rst_n === 1'b1 && bus.mem_req) begin
                if (mq.size() == 0) begin
                    chk("unexpected_mem_req", 1'b1, 1'b0);
                end else begin
                    m = mq.pop_front();
                    k = 0;
                    while (rst_n && bus.mem_req && k < 1000) begin
                        k++;
                        chk("mem_addr", bus.mem_addr, m.addr);
                        if (m.dly > 0 && k == m.dly) begin
                            bus.mem_ack = 1'b1;
                            bus.mem_rdata = m.rdata;
                        end else begin
                            bus.mem_rdata = {$urandom, $urandom};
                        end
                        @(negedge clk);
                        bus.mem_ack = 1'b0;
                    end
                    if (m.dly > 0) begin
                        chk("rd_cycles", 64'(k), 64'(m.dly));
`ifdef WBCTL_TIMEOUT_EN
                    end else if (m.dly == 0) begin
                        chk("tmo_cycles", 64'(k), 64'(TMO_TB));
`endif
                    end else begin
                        wait (rst_n);
                        repeat (2) @(negedge clk);
                        bus.mem_ack = 1'b1;
                        bus.mem_rdata = m.rdata;
                        @(negedge clk);
                        bus.mem_ack = 1'b0;
                    end
                end
            end else if (rst_n === 1'b1) begin
                bus.mem_ack = ($urandom_range(0, 3) == 0);
                bus.mem_rdata = {$urandom, $urandom};
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int          wc;
        int          n;
        logic [7:0]  opc;
        logic [63:0] c;
        rst_n = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_opc = 8'h81; bus.in_flg = 2'b11; bus.in_c = 64'hdead_beef;
        bus.in_addr = 64'h100; bus.in_rd = 4'd7;

        // Reset held with a valid instruction offered: nothing may be accepted.
        repeat (3) begin
            @(negedge clk);
            chk("rst_in_ready", bus.in_ready, 1'b1);
            chk("rst_mem_req", bus.mem_req, 1'b0);
            chk("rst_rf_we", bus.rf_we, 1'b0);
            chk("rst_err", bus.err, 1'b0);
            chk("rst_sel_c", bus.sel_c, 64'h0);
        end
        bus.in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", bus.in_ready, 1'b1);
        chk("post_rst_waddr", 64'(bus.rf_waddr), 64'h0);
        chk("post_rst_mem_addr", bus.mem_addr, 64'h0);
        chk("post_rst_sel_opc", 64'(bus.sel_opc), 64'h0);

        issue(8'h81, 2'b01, 64'h1234, 64'h0, 4'd3, 0, 64'h0, 1'b0);
        issue(MOVRA4, 2'b00, 64'h9, 64'h40, 4'd5, 4, 64'hFFFF_FFFF_8000_0001, 1'b0);
        issue(SETLE, 2'b10, 64'h1, 64'h0, 4'd6, 0, 64'h0, 1'b1);

`ifdef WBCTL_TIMEOUT_EN
        issue(MOVRA1, 2'b00, 64'h5, 64'h80, 4'd2, 0, 64'h0, 1'b0);
        issue(8'h90, 2'b00, 64'habcd, 64'h0, 4'd4, 0, 64'h0, 1'b1);
        chk("err_sticky", bus.err, 1'b1);
        issue(MOVRA4, 2'b01, 64'h6, 64'hc0, 4'd1, TMO_TB, 64'h1111_2222_3333_4444, 1'b0);
        issue(8'h82, 2'b00, 64'h7, 64'h0, 4'd8, 0, 64'h0, 1'b1);
        chk("err_still_set", bus.err, 1'b1);
`endif

        // Reset in the middle of RD; a later ack must not produce a writeback.
        issue(MOVRA1, 2'b01, 64'h77, 64'h88, 4'd9, -1, 64'h5555, 1'b0);
        wc = we_count;
        repeat (2) @(negedge clk);
        chk("rd_before_rst", bus.mem_req, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_drops_mem_req", bus.mem_req, 1'b0);
        chk("rst_ready_mid", bus.in_ready, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        chk("no_we_after_abort", 64'(we_count), 64'(wc));
        chk("abort_sel_d", bus.sel_d, 64'h0);
        chk("abort_err", bus.err, 1'b0);

        for (int i = 0; i < 150; i++) begin
            case ($urandom_range(0, 3))
                0:       opc = MOVRA4;
                1:       opc = MOVRA1;
                2:       opc = 8'($urandom) | 8'h80;
                default: opc = 8'($urandom);
            endcase
            c = {$urandom, $urandom};
            issue(opc, 2'($urandom), c, {$urandom, $urandom}, RW'($urandom),
                  $urandom_range(1, 6), {$urandom, $urandom}, 1'($urandom));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        n = 0;
        while ((sb.size() != 0 || mq.size() != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("sb_drained", 64'(sb.size()), 64'h0);
        chk("mq_drained", 64'(mq.size()), 64'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/wb_ctrl.md
# wb_ctrl

Writeback controller that sequences the result selector and the register-file write port. It accepts one decoded instruction at a time (opcode, flags, ALU result, address, destination register). For memory-sourced moves it runs a single-beat read handshake, captures the read data, then presents opcode, flags, ALU result and data to the selector and pulses the register-file write enable. It sits between decode/execute and the register file and stalls issue while a load is outstanding.

## Interface
- `RW`, default 4: register-file address width.
- `TMO`, default 255: memory-ack timeout in cycles (used only with the timeout macro).
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `in_valid`  in  1  instruction offered.
- `in_ready`  out  1  controller can accept; high only in IDLE.
- `in_opc`  in  8  opcode, same encoding as `inst.v`.
- `in_flg`  in  2  flags; [0] = equal, [1] = less.
- `in_c`  in  64  ALU result.
- `in_addr`  in  64  memory address for loads.
- `in_rd`  in  RW  destination register.
- `mem_req`  out  1  read request.
- `mem_addr`  out  64  read address.
- `mem_ack`  in  1  read data valid.
- `mem_rdata`  in  64  read data.
- `sel_opc`  out  8  opcode to the selector.
- `sel_flg`  out  2  flags to the selector.
- `sel_c`  out  64  ALU result to the selector.
- `sel_d`  out  64  data to the selector.
- `rf_we`  out  1  register write strobe (one cycle).
- `rf_waddr`  out  RW  register write address.
- `err`  out  1  sticky timeout flag (timeout build only; otherwise tied 0).

## Operation
- States: IDLE, RD, WB. Reset values: state IDLE; all `sel_*`, `mem_addr` and `rf_waddr` are 0; `mem_req`, `rf_we` and `err` are 0; `in_ready` is 1.
- Accept: `in_valid & in_ready` at an edge. All `in_*` fields are latched into holding registers and drive `sel_*`, `mem_addr` and `rf_waddr` from the next cycle.
- Load classification: `in_opc[7]==0` and the opcode is `MOVRA4` or `MOVRA1` → IDLE→RD. Every other opcode → IDLE→WB.
- For non-load opcodes, `sel_d` is latched from `in_c`; the selector's default path then forwards it unchanged.
- RD: `mem_req` is 1 for the whole state and `mem_addr` is held. When `mem_ack` is seen at an edge, `mem_rdata` is latched into `sel_d` and the state goes to WB. `mem_ack` outside RD is ignored.
- WB: `rf_we`=1 for exactly one cycle, then the state returns to IDLE. `in_ready` is 0 in WB, so there is no back-to-back accept; the minimum issue interval is 2 cycles.
- Holding registers keep their values after WB until the next accept. `sel_*` are therefore stable throughout RD and WB.
- Reset mid-operation: an asynchronous return to the reset values. Any outstanding request is dropped, and the memory side must tolerate `mem_req` falling without an ack.

## Timing
- Non-load: accept at edge N → `rf_we` high during cycle N+1 → `in_ready` high at N+2.
- Load: accept at edge N → `mem_req` high from N+1. If ack is sampled at edge M: `rf_we` is high during M+1 and `in_ready` returns at M+2.
- Ack in the first RD cycle (M=N+1) gives 3-cycle accept-to-ready.
- `mem_req` deasserts on the edge after the ack.

## Configuration
- `WBCTL_TIMEOUT_EN` defined:
  - An 8-bit-or-wider counter clears on RD entry and increments each RD cycle without ack.
  - Reaching `TMO` without an ack: go to IDLE with no `rf_we` and set `err`. `err` stays set until `rst_n`.
  - An ack in the same cycle as the limit wins, and the load completes normally.
- Undefined: no counter and RD waits indefinitely. `err` is constant 0.

## Test plan
- Reset: hold `rst_n`=0 with `in_valid`=1 → `in_ready`=1, `mem_req`=0, `rf_we`=0, `err`=0, and no accept occurs.
- ALU op (`in_opc[7]`=1, `in_c`=64'h1234, `in_rd`=3) → `rf_we` for one cycle one edge after accept, `rf_waddr`=3, `sel_c`=64'h1234, and `mem_req` never rises.
- `MOVRA4` with `in_addr`=64'h40 and ack after 4 RD cycles with `mem_rdata`=64'hFFFF_FFFF_8000_0001 → `mem_addr`=64'h40 held for 4 cycles, `sel_d` equals `mem_rdata`, and `rf_we` is one cycle after ack.
- `SETLE` with `in_flg`=2'b10 back-to-back after a load → accepted only once `in_ready`=1, `sel_flg`=2'b10, `rf_we` one edge later.
- `rst_n` pulsed low during RD → `mem_req` drops immediately, and a later `mem_ack` produces no `rf_we`.
- With `WBCTL_TIMEOUT_EN`, `TMO`=8 and no ack → IDLE after 8 RD cycles, `err`=1, no `rf_we`; the next ALU op still writes back normally.
